// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants and fetch FSM state type
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry {pc, instr} buffer with push/pop/flush and occupancy
module fetch_fifo #(
  parameter int           W           = 64,
  parameter logic [W-1:0] RESET_ENTRY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign push_ok = push && (count_q != 2'd2);
  assign pop_ok  = pop && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    if (flush) count_d = 2'd0;
    else       count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Flush keeps the storage; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= RESET_ENTRY;
      mem_q[1] <= RESET_ENTRY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= count_d;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, single-outstanding imem fetch, redirect; FETCH_PERF_CNT_EN adds counters
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [5:0]            opcode,
  output logic [5:0]            funct,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic                  instr_ready,
  input  logic                  jump,
  input  logic                  branch_taken
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int EW = ADDR_WIDTH + 32;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [ADDR_WIDTH-1:0] head_pc, target, br_off;
  logic [31:0]           head_instr;
  logic [EW-1:0]         head_data;
  logic                  fifo_full, fifo_empty, push, pop, redirect;
  logic [1:0]            fifo_count;

  fetch_fifo #(
    .W          (EW),
    .RESET_ENTRY({RESET_PC, 32'h0})
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({req_addr_q, imem_rdata}),
    .pop      (pop),
    .flush    (redirect),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign head_pc     = head_data[EW-1:32];
  assign head_instr  = head_data[31:0];
  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head_instr : 32'h0;
  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign pc_plus4    = head_pc + ADDR_WIDTH'(4);
  assign imem_addr   = fetch_pc_q;

  assign pop      = instr_valid && instr_ready;
  assign redirect = pop && (jump || branch_taken);
  assign br_off   = {{(ADDR_WIDTH-18){head_instr[15]}}, head_instr[15:0], 2'b00};
  assign target   = jump ? {pc_plus4[ADDR_WIDTH-1:28], head_instr[25:0], 2'b00}
                         : pc_plus4 + br_off;

  // The pending response already owns a slot, so IDLE only needs the FIFO count.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    push     = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (!rst && !redirect && fifo_count < 2'd2) begin
          imem_req = 1'b1;
          state_d  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          push    = !redirect && !fifo_full;
          state_d = FS_IDLE;
        end else if (redirect) begin
          state_d = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        if (imem_rvalid) state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)      fetch_pc_d = target;
    else if (imem_req) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (imem_req) req_addr_q <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (imem_req) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, instr_valid, instr_ready, jump, branch_taken;
  logic [31:0] imem_addr, imem_rdata, instr, pc_plus4;
  logic [5:0]  opcode, funct;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc_plus4    (pc_plus4),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch_taken(branch_taken)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req), 32'd0);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_pc4"},   pc_plus4, 32'h4);
  endtask

  initial begin
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    cyc(); cyc();
    check_reset_outputs("reset");

    // first fetch, 1-cycle memory
    rst = 1'b0; #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    cyc();
    check("wait_no_req", 32'(imem_req), 32'd0);
    check("wait_not_valid", 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    cyc(); imem_rvalid = 1'b0; #1;
    check("lat_valid", 32'(instr_valid), 32'd1);
    check("lat_instr", instr, 32'h2008_0005);
    check("lat_opcode", 32'(opcode), 32'(OP_ADDI));
    check("lat_funct", 32'(funct), 32'h5);
    check("lat_pc4", pc_plus4, 32'h4);
    check("second_req", 32'(imem_req), 32'd1);
    check("second_addr", imem_addr, 32'h4);

    // hold instr_ready low: FIFO fills, requests stop
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'h2009_000A;
    cyc(); imem_rvalid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("full_no_req", 32'(imem_req), 32'd0);
      check("full_head", instr, 32'h2008_0005);
      cyc();
    end

    // drain both entries while fetching 0x8
    instr_ready = 1'b1; #1;
    check("pop_full_no_req", 32'(imem_req), 32'd0);
    cyc();
    check("pop1_instr", instr, 32'h2009_000A);
    check("pop1_pc4", pc_plus4, 32'h8);
    check("pop1_req", 32'(imem_req), 32'd1);
    check("pop1_addr", imem_addr, 32'h8);
    cyc(); instr_ready = 1'b0; #1;
    check("empty_valid", 32'(instr_valid), 32'd0);
    check("empty_wait_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0800_0010;
    cyc(); imem_rvalid = 1'b0; #1;
    check("j8_instr", instr, 32'h0800_0010);
    check("j8_opcode", 32'(opcode), 32'(OP_J));
    check("j8_pc4", pc_plus4, 32'hC);
    check("j8_pre_addr", imem_addr, 32'hC);

    // jump at pc 0x8 -> 0x40
    instr_ready = 1'b1; jump = 1'b1; #1;
    check("jump_cycle_no_req", 32'(imem_req), 32'd0);
    cyc(); instr_ready = 1'b0; jump = 1'b0; #1;
    check("jump_flushed", 32'(instr_valid), 32'd0);
    check("jump_req", 32'(imem_req), 32'd1);
    check("jump_addr", imem_addr, 32'h40);

    // jump at pc 0x40 -> 0x10
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'h0800_0004;
    cyc(); imem_rvalid = 1'b0; #1;
    check("j40_pc4", pc_plus4, 32'h44);
    check("j40_addr", imem_addr, 32'h44);
    instr_ready = 1'b1; jump = 1'b1; #1;
    check("j40_no_req", 32'(imem_req), 32'd0);
    cyc(); instr_ready = 1'b0; jump = 1'b0; #1;
    check("j40_req", 32'(imem_req), 32'd1);
    check("j40_target", imem_addr, 32'h10);

    // beq imm=-1 at pc 0x10; branch_taken without pop is ignored
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'h1000_FFFF;
    cyc(); imem_rvalid = 1'b0; branch_taken = 1'b1; #1;
    check("beq_opcode", 32'(opcode), 32'(OP_BEQ));
    check("beq_pc4", pc_plus4, 32'h14);
    check("bt_nopop_req", 32'(imem_req), 32'd1);
    check("bt_nopop_addr", imem_addr, 32'h14);

    // redirect while WAIT, response arrives 3 cycles after request
    cyc(); instr_ready = 1'b1; #1;
    check("bt_wait_valid", 32'(instr_valid), 32'd1);
    check("bt_wait_no_req", 32'(imem_req), 32'd0);
    cyc(); instr_ready = 1'b0; branch_taken = 1'b0; #1;
    check("drain_valid", 32'(instr_valid), 32'd0);
    check("drain_no_req", 32'(imem_req), 32'd0);
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_0014; #1;
    check("drain_rsp_no_req", 32'(imem_req), 32'd0);
    cyc(); imem_rvalid = 1'b0; #1;
    check("drain_stale_valid", 32'(instr_valid), 32'd0);
    check("drain_stale_instr", instr, 32'h0);
    check("drain_req", 32'(imem_req), 32'd1);
    check("drain_target", imem_addr, 32'h10);

    // redirect in the same cycle as the response
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'h1000_FFFF;
    cyc(); imem_rvalid = 1'b0; #1;
    check("same_head_valid", 32'(instr_valid), 32'd1);
    check("same_pre_addr", imem_addr, 32'h14);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_0014; instr_ready = 1'b1; branch_taken = 1'b1; #1;
    check("same_no_req", 32'(imem_req), 32'd0);
    cyc(); imem_rvalid = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; #1;
    check("same_dropped", 32'(instr_valid), 32'd0);
    check("same_req", 32'(imem_req), 32'd1);
    check("same_target", imem_addr, 32'h10);

    // reset mid-WAIT, late response lands in IDLE and is ignored
    cyc(); rst = 1'b1;
    cyc();
    check_reset_outputs("midrst");
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("postrst_req", 32'(imem_req), 32'd1);
    check("postrst_addr", imem_addr, 32'h0);
    cyc(); imem_rvalid = 1'b0; #1;
    check("postrst_stale", 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    cyc(); imem_rvalid = 1'b0; #1;
    check("postrst_valid", 32'(instr_valid), 32'd1);
    check("postrst_instr", instr, 32'h2008_0005);
    check("postrst_pc4", pc_plus4, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding the main decoder. It holds the program counter, issues word reads to instruction memory over a single-outstanding request/response handshake, buffers returned words in a 2-entry FIFO, and presents the head instruction with its Opcode/Funct fields and PC+4. Jump and taken-branch decisions from the control path redirect the PC and flush in-flight fetches.

## Interface
- `ADDR_WIDTH`, 32: PC and instruction memory address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  one-cycle read request pulse.
- `imem_addr`  out  ADDR_WIDTH  byte address of the request; valid when `imem_req`=1.
- `imem_rvalid`  in  1  read data valid; at least 1 cycle after its request.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  FIFO head holds an instruction.
- `instr`  out  32  head instruction word.
- `opcode`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `pc_plus4`  out  ADDR_WIDTH  head PC + 4.
- `instr_ready`  in  1  downstream consumes head this cycle.
- `jump`  in  1  head is a jump; qualified by `instr_valid && instr_ready`.
- `branch_taken`  in  1  head is a taken beq (Branch & Zero); same qualifier.

## Operation
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE: if FIFO has a free slot (occupancy < 2, counting the pending slot) and no redirect this cycle, pulse `imem_req` with `imem_addr`=fetch_pc, fetch_pc += 4, go WAIT.
  - WAIT: on `imem_rvalid`, push `{imem_rdata, addr}` into FIFO, go IDLE.
  - DRAIN: on `imem_rvalid`, discard data, go IDLE.
- Slot reservation: request issued only when occupancy + outstanding < 2, so FIFO never overflows.
- Pop: `instr_valid && instr_ready` removes the head.
- Redirect (on a pop only): `jump` → target `{pc_plus4[31:28], instr[25:0], 2'b00}`; else `branch_taken` → target `pc_plus4 + (sext(instr[15:0]) << 2)`. Jump has priority.
- On redirect: FIFO cleared, fetch_pc ← target; if in WAIT with no `imem_rvalid` this cycle → DRAIN; if `imem_rvalid` same cycle → response dropped, go IDLE; no request issued in the redirect cycle.
- `jump`/`branch_taken` without a pop are ignored.
- Address arithmetic modulo 2^ADDR_WIDTH; wrap from all-ones to 0 is silent. Low two address bits always 0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `pc_plus4`=RESET_PC+4, FSM=IDLE, FIFO empty, fetch_pc=RESET_PC. Reset mid-WAIT abandons the response; a later `imem_rvalid` in IDLE is ignored.
- First request: cycle after reset deasserts.
- Latency with 1-cycle memory: req at cycle N, rvalid N+1, `instr_valid` at N+2 (registered FIFO).
- Steady-state throughput with 1-cycle memory: one instruction per 2 cycles (single outstanding).
- Redirect at edge N: first request to target at N+1 (IDLE) or after drained response (DRAIN).
- Simultaneous push and pop: both occur; occupancy unchanged.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds outputs `fetch_cnt` (32, requests issued) and `flush_cnt` (32, redirects taken), reset to 0, wrapping at 2^32. When undefined, ports and counters are absent; behaviour otherwise identical.

## Structure
- Shared package `mips_pkg`: opcode constants (lw, sw, R-type, addi, beq, j), funct constants, fetch FSM state enum, `RESET_PC` default.
- One sub-module: `fetch_fifo` (2-entry, 64-bit entries `{pc, instr}`, push/pop/flush, full/empty, occupancy).

## Test plan
- Reset, memory returning `0x20080005` at addr 0 after 1 cycle → `instr_valid`=1 at cycle 3, `opcode`=6'h08, `pc_plus4`=4.
- `instr_ready`=0 held → exactly two requests (addr 0, 4), then `imem_req` stays 0; FIFO full.
- Head `0x08000010` at pc 0x8 popped with `jump`=1 → FIFO flushed, next `imem_addr`=0x40.
- Head beq imm=0xFFFF at pc 0x10 popped with `branch_taken`=1 → next `imem_addr`=0x10.
- Redirect while WAIT, memory latency 3 → DRAIN, stale word never appears on `instr`, next request to target.
- Redirect same cycle as `imem_rvalid`; and `rst` mid-WAIT → no stale instruction; outputs return to reset values.
